sar_search: RTL

Successive-approximation search controller that drives probe values into an external magnitude comparator and uses the comparator's greater, less and equal flags to binary-search an unknown WIDTH-bit target. It is the initiator side of the comparator interface: the comparator answers "how does the target relate to this probe", and this block decides the next probe. Typical use is threshold or code discovery against a 4-bit comparator, with the comparator either combinational and always valid, or registered and handshaken.

---
 rtl/sar_search.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sar_search.sv
// Binary-search initiator for an external magnitude comparator.
// Narrows [lo, hi] on each accepted gt/lt answer until eq, exhaustion or a bad flag set.
module sar_search #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] probe,
    output logic             probe_valid,
    input  logic             cmp_valid,
    input  logic             gt_in,
    input  logic             lt_in,
    input  logic             eq_in,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             error,
    output logic [WIDTH-1:0] result,
    output logic [CW-1:0]    probes
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROBE,
        S_DONE
    } state_t;

    localparam logic [WIDTH:0]   MAXV = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] MAXP = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MID0 = WIDTH'(MAXV >> 1);

    state_t           state;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;

    logic             accept;
    logic [2:0]       flags;
    logic [WIDTH:0]   lo_w;
    logic [WIDTH:0]   hi_w;
    logic [WIDTH:0]   inc_w;
    logic [WIDTH:0]   dec_w;

    logic             end_s;
    logic             hit;
    logic             bad;
    logic [WIDTH-1:0] nxt_lo;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_probe;

    assign accept = probe_valid & cmp_valid;
    assign flags  = {gt_in, lt_in, eq_in};
    assign lo_w   = {1'b0, lo};
    assign hi_w   = {1'b0, hi};
    assign inc_w  = {1'b0, probe} + 1'b1;
    assign dec_w  = {1'b0, probe} - 1'b1;

    // Midpoints are formed one bit wider so lo+hi never wraps.
    always_comb begin
        end_s     = 1'b0;
        hit       = 1'b0;
        bad       = 1'b0;
        nxt_lo    = lo;
        nxt_hi    = hi;
        nxt_probe = probe;
        unique case (flags)
            3'b001: begin
                end_s = 1'b1;
                hit   = 1'b1;
            end
            3'b100: begin
                if (probe == MAXP) begin
                    end_s = 1'b1;
                end else begin
                    nxt_lo    = inc_w[WIDTH-1:0];
                    nxt_probe = WIDTH'((inc_w + hi_w) >> 1);
                    end_s     = (inc_w > hi_w);
                end
            end
            3'b010: begin
                if (probe == '0) begin
                    end_s = 1'b1;
                end else begin
                    nxt_hi    = dec_w[WIDTH-1:0];
                    nxt_probe = WIDTH'((lo_w + dec_w) >> 1);
                    end_s     = (lo_w > dec_w);
                end
            end
            default: begin
                end_s = 1'b1;
                bad   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            lo          <= '0;
            hi          <= '0;
            probe       <= '0;
            probe_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            error       <= 1'b0;
            result      <= '0;
            probes      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        lo          <= '0;
                        hi          <= MAXP;
                        probe       <= MID0;
                        probes      <= '0;
                        found       <= 1'b0;
                        error       <= 1'b0;
                        result      <= '0;
                        probe_valid <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    if (accept) begin
                        probes <= probes + CW'(1);
                        if (end_s) begin
                            state       <= S_DONE;
                            done        <= 1'b1;
                            probe_valid <= 1'b0;
                            busy        <= 1'b0;
                            found       <= hit;
                            error       <= bad;
                            result      <= hit ? probe : '0;
                        end else begin
                            lo    <= nxt_lo;
                            hi    <= nxt_hi;
                            probe <= nxt_probe;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
